div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Requester-side sequencer for the ALU's multi-cycle divide/remainder path (aluc 20..23).
- Sits between the execute stage and the ALU:
  - passes single-cycle ops straight through;
  - on a div/rem op, latches and holds operands and stalls the pipeline;
  - waits for the ALU's one-cycle completion pulse, captures the result and issues a one-cycle writeback.
- Also handles flush-while-busy, a watchdog timeout and a stall-cycle performance counter.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in WAIT before the watchdog fires; must be > 40.
- CNT_W, 7: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute-stage op valid.
- req_aluc  in  5  ALU opcode of the execute-stage op.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_rd  in  5  destination register.
- flush  in  1  pipeline flush; kills the in-flight op.
- alu_aluc  out  5  opcode to the ALU.
- alu_a  out  32  operand A to the ALU.
- alu_b  out  32  operand B to the ALU.
- alu_result  in  32  ALU Result.
- alu_div_ready  in  1  ALU divReady; one-cycle pulse in the ALU's DONE cycle.
- stall  out  1  freeze upstream pipeline stages.
- wb_valid  out  1  div/rem result valid this cycle.
- wb_rd  out  5  writeback destination.
- wb_data  out  32  writeback data.
- timeout_err  out  1  sticky watchdog error.
- perf_stall_cycles  out  32  saturating count of cycles with stall=1.

Behaviour:
- Clock and reset: one clock domain, CLK. RESET is asynchronous and active-low.
- Reset values:
  - state=IDLE; all hold registers, wb_data, wb_rd, watchdog counter = 0.
  - wb_valid=0, stall=0, timeout_err=0, perf_stall_cycles=0.
  - Reset mid-operation aborts immediately; the ALU shares the same reset.
- is_div = (req_aluc >= 20) && (req_aluc <= 23).
- State IDLE:
  - alu_aluc/alu_a/alu_b = req_aluc/req_a/req_b, combinational passthrough.
  - If req_valid && is_div && !flush:
    - stall=1 combinationally in this cycle;
    - latch aluc/a/b/rd into hold registers;
    - clear the watchdog counter;
    - next state WAIT.
  - Otherwise stall=0 and the state stays IDLE.
  - The ALU sees the div opcode in this same cycle and starts at the same edge.
- State WAIT:
  - ALU ports driven from the hold registers, which stay stable every cycle; the ALU re-checks operands while busy.
  - stall=1; the watchdog counter increments each cycle.
  - alu_div_ready && !flush: wb_data<=alu_result, wb_rd<=held rd; next state RESP.
  - flush with alu_div_ready in the same cycle: result discarded; next state IDLE.
  - flush without alu_div_ready: next state DRAIN.
  - Counter == TIMEOUT_CYCLES-1 with no ready: timeout_err<=1; next state IDLE; no writeback.
- State DRAIN:
  - Hold registers still drive the ALU; stall=1.
  - On alu_div_ready: result dropped; next state IDLE.
  - The watchdog stays active here and behaves as in WAIT.
- State RESP:
  - alu_aluc=5'd0 (ADD), alu_a=alu_b=0. This prevents the ALU from restarting after its DONE cycle.
  - stall=0; req is ignored.
  - wb_valid = !flush (combinational); wb_rd/wb_data come from registers.
  - Next state IDLE unconditionally.
- Latency, with the accept cycle numbered 0:
  - Normal divide: ALU busy cycles 1..33, alu_div_ready in cycle 34, wb_valid in cycle 35. stall=1 for cycles 0..34 (35 cycles).
  - Divide by zero, or signed 0x80000000 / 0xFFFFFFFF: ready in cycle 2, wb_valid in cycle 3.
- perf_stall_cycles increments every cycle stall=1 and saturates at 0xFFFFFFFF.
- timeout_err is cleared only by reset.
- alu_div_ready seen in IDLE or RESP is ignored.

Test Plan:
- DIVU 100/7, req_valid held → stall cycles 0–34; wb_valid only in cycle 35 with wb_data=14; perf_stall_cycles=35.
- DIV 0xFFFFFF9C (-100) / 7 → wb_data=0xFFFFFFF2 (-14). Then REM -100/7 → wb_data=0xFFFFFFFE (-2).
- DIVU 5/0 → wb_valid in cycle 3, wb_data=0xFFFFFFFF. REMU 5/0 → wb_data=5. DIV 0x80000000/0xFFFFFFFF → wb_data=0x80000000.
- Flush at cycle 10 of a DIVU → stall held until ready (cycle 34); no wb_valid. IDLE at cycle 35 accepts an ADD passthrough with stall=0.
- Stub ALU that never pulses ready → after 64 WAIT cycles timeout_err=1 (sticky), stall=0, no wb_valid. RESET low mid-WAIT → all outputs 0 at once.
- Back-to-back DIVU then REMU, req held during stall → the RESP cycle drives alu_aluc=0. Second op accepted in cycle 36; two wb_valid pulses, in cycles 35 and 71.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl_if
// Bundles the execute-stage request, the ALU connection and the writeback /
// status outputs of the divide issue sequencer.
//   slave  : the sequencer itself (consumes requests and ALU status, drives
//            ALU operands, stall, writeback and status)
//   master : the environment (execute stage + ALU)
// Signals:
//   req_valid/req_aluc/req_a/req_b/req_rd : execute-stage op
//   flush                                  : kills the in-flight op
//   alu_aluc/alu_a/alu_b                   : opcode/operands to the ALU
//   alu_result/alu_div_ready               : ALU result and DONE pulse
//   stall                                  : freeze upstream stages
//   wb_valid/wb_rd/wb_data                 : div/rem writeback
//   timeout_err                            : sticky watchdog error
//   perf_stall_cycles                      : saturating stall-cycle count
// -----------------------------------------------------------------------------
interface div_issue_ctrl_if;
    logic        req_valid;
    logic [4:0]  req_aluc;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        flush;
    logic [4:0]  alu_aluc;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_div_ready;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout_err;
    logic [31:0] perf_stall_cycles;

    modport slave (
        input  req_valid, req_aluc, req_a, req_b, req_rd, flush,
        input  alu_result, alu_div_ready,
        output alu_aluc, alu_a, alu_b,
        output stall, wb_valid, wb_rd, wb_data, timeout_err, perf_stall_cycles
    );

    modport master (
        output req_valid, req_aluc, req_a, req_b, req_rd, flush,
        output alu_result, alu_div_ready,
        input  alu_aluc, alu_a, alu_b,
        input  stall, wb_valid, wb_rd, wb_data, timeout_err, perf_stall_cycles
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
// Requester-side sequencer for the ALU's multi-cycle divide/remainder path
// (aluc 20..23). Single-cycle ops pass straight through to the ALU. A div/rem
// op is latched into hold registers, the pipeline is stalled, and the ALU's
// one-cycle completion pulse is turned into a one-cycle writeback. Handles a
// flush while busy (the ALU is allowed to finish, the result is dropped), a
// watchdog timeout and a saturating stall-cycle counter.
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous active-low reset
//   bus   : div_issue_ctrl_if.slave (request, ALU, writeback, status)
// Parameters:
//   TIMEOUT_CYCLES : max cycles spent waiting before the watchdog fires (> 40)
//   CNT_W          : watchdog counter width, 2**CNT_W > TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input logic             CLK,
    input logic             RESET,
    div_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      PERF_MAX = 32'hFFFF_FFFF;

    state_t           r_state;
    logic [4:0]       r_hold_aluc;
    logic [31:0]      r_hold_a;
    logic [31:0]      r_hold_b;
    logic [4:0]       r_hold_rd;
    logic [CNT_W-1:0] r_wd_cnt;
    logic [4:0]       r_wb_rd;
    logic [31:0]      r_wb_data;
    logic             r_timeout_err;
    logic [31:0]      r_perf;

    logic             w_is_div;
    logic             w_accept;
    logic             w_wd_expired;
    logic             w_stall;
    logic             w_wb_valid;
    logic [4:0]       w_alu_aluc;
    logic [31:0]      w_alu_a;
    logic [31:0]      w_alu_b;

    function automatic logic is_div_op(input logic [4:0] aluc);
        return (aluc >= 5'd20) && (aluc <= 5'd23);
    endfunction

    assign w_is_div     = is_div_op(bus.req_aluc);
    assign w_accept     = bus.req_valid && w_is_div && !bus.flush;
    assign w_wd_expired = (r_wd_cnt == WD_LAST);

    // Output decode: ALU operand source, stall and writeback strobe per state.
    always_comb begin
        w_alu_aluc = 5'd0;
        w_alu_a    = 32'd0;
        w_alu_b    = 32'd0;
        w_stall    = 1'b0;
        w_wb_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The ALU sees the div opcode in the accept cycle and starts
                // on the same edge that moves us to WAIT.
                w_alu_aluc = bus.req_aluc;
                w_alu_a    = bus.req_a;
                w_alu_b    = bus.req_b;
                w_stall    = w_accept;
            end
            ST_WAIT, ST_DRAIN: begin
                // The ALU re-checks its operands while busy, so they must
                // stay stable until DONE even after a flush.
                w_alu_aluc = r_hold_aluc;
                w_alu_a    = r_hold_a;
                w_alu_b    = r_hold_b;
                w_stall    = 1'b1;
            end
            ST_RESP: begin
                // ADD with zero operands keeps the ALU from restarting the
                // divide in the cycle after DONE.
                w_alu_aluc = 5'd0;
                w_alu_a    = 32'd0;
                w_alu_b    = 32'd0;
                w_stall    = 1'b0;
                w_wb_valid = !bus.flush;
            end
            default: begin
                w_alu_aluc = 5'd0;
                w_alu_a    = 32'd0;
                w_alu_b    = 32'd0;
                w_stall    = 1'b0;
                w_wb_valid = 1'b0;
            end
        endcase
    end

    // Sequencer state, hold registers, watchdog, writeback and perf counter.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= ST_IDLE;
            r_hold_aluc   <= 5'd0;
            r_hold_a      <= 32'd0;
            r_hold_b      <= 32'd0;
            r_hold_rd     <= 5'd0;
            r_wd_cnt      <= '0;
            r_wb_rd       <= 5'd0;
            r_wb_data     <= 32'd0;
            r_timeout_err <= 1'b0;
            r_perf        <= 32'd0;
        end else begin
            if (w_stall && (r_perf != PERF_MAX)) begin
                r_perf <= r_perf + 32'd1;
            end else begin
                r_perf <= r_perf;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_hold_aluc <= bus.req_aluc;
                        r_hold_a    <= bus.req_a;
                        r_hold_b    <= bus.req_b;
                        r_hold_rd   <= bus.req_rd;
                        r_wd_cnt    <= '0;
                        r_state     <= ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    r_wd_cnt <= r_wd_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (bus.alu_div_ready && !bus.flush) begin
                        r_wb_data <= bus.alu_result;
                        r_wb_rd   <= r_hold_rd;
                        r_state   <= ST_RESP;
                    end else if (bus.alu_div_ready) begin
                        // Flushed in the DONE cycle: nothing left to drain.
                        r_state <= ST_IDLE;
                    end else if (w_wd_expired) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else if (bus.flush) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    // Let the ALU finish the killed op so it is idle before
                    // the next divide is issued; the result is dropped.
                    r_wd_cnt <= r_wd_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (bus.alu_div_ready) begin
                        r_state <= ST_IDLE;
                    end else if (w_wd_expired) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.alu_aluc          = w_alu_aluc;
    assign bus.alu_a             = w_alu_a;
    assign bus.alu_b             = w_alu_b;
    assign bus.stall             = w_stall;
    assign bus.wb_valid          = w_wb_valid;
    assign bus.wb_rd             = r_wb_rd;
    assign bus.wb_data           = r_wb_data;
    assign bus.timeout_err       = r_timeout_err;
    assign bus.perf_stall_cycles = r_perf;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_issue_ctrl
// Drives div_issue_ctrl with directed and random ops against a behavioural
// divider ALU. Expected stall/writeback timing comes from the op's latency
// (34 cycles to ready, 2 for divide-by-zero / signed overflow) and the cycle
// of any flush; expected results come from plain arithmetic.
// ALU opcodes used here: 20=DIV 21=DIVU 22=REM 23=REMU, 0=ADD.
// -----------------------------------------------------------------------------
module tb_div_issue_ctrl;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_DIV  = 5'd20;
    localparam logic [4:0] OP_DIVU = 5'd21;
    localparam logic [4:0] OP_REM  = 5'd22;
    localparam logic [4:0] OP_REMU = 5'd23;

    logic clk;
    logic rst_n;
    logic alu_en;
    int   n_checks;
    int   n_errors;
    logic [31:0] exp_perf;

    div_issue_ctrl_if bus ();

    div_issue_ctrl #(
        .TIMEOUT_CYCLES (64),
        .CNT_W          (7)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic is_div(input logic [4:0] op);
        return (op >= 5'd20) && (op <= 5'd23);
    endfunction

    function automatic logic is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) ||
               (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    endfunction

    // Cycle (accept = 0) in which the ALU pulses ready.
    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        return is_special(op, a, b) ? 2 : 34;
    endfunction

    function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_DIV: begin
                if (b == 32'd0)  return 32'hFFFF_FFFF;
                else if (ovf)    return 32'h8000_0000;
                else begin sr = sa / sb; return sr; end
            end
            OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 32'd0)  return a;
                else if (ovf)    return 32'd0;
                else begin sr = sa % sb; return sr; end
            end
            OP_REMU: return (b == 32'd0) ? a : a % b;
            default: return a + b;
        endcase
    endfunction

    // Behavioural divider ALU: starts when idle and shown a div opcode,
    // pulses ready in its DONE cycle; alu_en=0 models a stuck ALU.
    logic        alu_busy;
    int          alu_cnt;
    int          alu_lat;
    logic [31:0] alu_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_busy <= 1'b0;
            alu_cnt  <= 0;
            alu_lat  <= 34;
            alu_res  <= 32'd0;
        end else if (!alu_busy) begin
            if (is_div(bus.alu_aluc)) begin
                alu_busy <= 1'b1;
                alu_cnt  <= 1;
                alu_lat  <= ref_lat(bus.alu_aluc, bus.alu_a, bus.alu_b);
                alu_res  <= ref_div(bus.alu_aluc, bus.alu_a, bus.alu_b);
            end
        end else if (alu_en && (alu_cnt == alu_lat)) begin
            alu_busy <= 1'b0;
        end else begin
            alu_cnt <= alu_cnt + 1;
        end
    end

    assign bus.alu_div_ready = alu_busy && alu_en && (alu_cnt == alu_lat);
    assign bus.alu_result    = alu_busy ? alu_res : (bus.alu_a + bus.alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one op from its accept cycle until the sequencer is idle again.
    // flush_at: cycle (relative to accept) in which flush is raised, -1 none.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int flush_at);
        int          lat;
        logic [31:0] exp_data;
        logic [31:0] drv_a;
        logic [31:0] drv_b;
        logic        killed;
        logic        exp_wb;
        if (!is_div(op)) begin
            bus.req_valid = 1'b1; bus.req_aluc = op; bus.req_a = a; bus.req_b = b;
            bus.req_rd = rd; bus.flush = 1'b0;
            @(negedge clk);
            chk("pt_stall", {31'd0, bus.stall}, 32'd0);
            chk("pt_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
            chk("pt_aluc", {27'd0, bus.alu_aluc}, {27'd0, op});
            chk("pt_a", bus.alu_a, a);
            chk("pt_b", bus.alu_b, b);
            @(posedge clk); #1;
            return;
        end
        lat      = ref_lat(op, a, b);
        exp_data = ref_div(op, a, b);
        for (int k = 0; k <= lat + 1; k++) begin
            killed    = (flush_at >= 1) && (flush_at < k);
            bus.flush = (k == flush_at);
            drv_a     = (k == 0) ? a : $urandom;
            drv_b     = (k == 0) ? b : $urandom;
            bus.req_a = drv_a;
            bus.req_b = drv_b;
            bus.req_rd = rd;
            bus.req_valid = 1'b1;
            // Once killed, the upstream slot carries a plain ADD.
            bus.req_aluc = killed ? OP_ADD : op;
            @(negedge clk);
            exp_wb = (k == lat + 1) && !((flush_at >= 1) && (flush_at <= lat + 1));
            chk("stall", {31'd0, bus.stall}, {31'd0, (k <= lat)});
            chk("wb_valid", {31'd0, bus.wb_valid}, {31'd0, exp_wb});
            if (k == 0) begin
                chk("issue_aluc", {27'd0, bus.alu_aluc}, {27'd0, op});
            end else if (k <= lat) begin
                chk("hold_aluc", {27'd0, bus.alu_aluc}, {27'd0, op});
                chk("hold_a", bus.alu_a, a);
                chk("hold_b", bus.alu_b, b);
            end else if ((flush_at < 1) || (flush_at == lat + 1)) begin
                chk("resp_aluc", {27'd0, bus.alu_aluc}, 32'd0);
                chk("resp_a", bus.alu_a, 32'd0);
            end else begin
                chk("idle_pt_aluc", {27'd0, bus.alu_aluc}, 32'd0);
                chk("idle_pt_a", bus.alu_a, drv_a);
            end
            if (exp_wb) begin
                chk("wb_data", bus.wb_data, exp_data);
                chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, rd});
            end
            if (k == lat + 1) begin
                exp_perf = exp_perf + 32'(lat + 1);
                chk("perf", bus.perf_stall_cycles, exp_perf);
            end
            @(posedge clk); #1;
        end
        bus.flush = 1'b0;
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        int          fl;
        n_checks = 0;
        n_errors = 0;
        exp_perf = 32'd0;
        alu_en   = 1'b1;
        rst_n    = 1'b0;
        bus.req_valid = 1'b0; bus.req_aluc = 5'd0; bus.req_a = 32'd0;
        bus.req_b = 32'd0; bus.req_rd = 5'd0; bus.flush = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        chk("rst_timeout", {31'd0, bus.timeout_err}, 32'd0);
        chk("rst_perf", bus.perf_stall_cycles, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed ops
        run_op(OP_DIVU, 32'd100, 32'd7, 5'd3, -1);
        run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd4, -1);
        run_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd5, -1);
        run_op(OP_DIVU, 32'd5, 32'd0, 5'd6, -1);
        run_op(OP_REMU, 32'd5, 32'd0, 5'd7, -1);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, -1);
        run_op(OP_DIVU, 32'd1000, 32'd9, 5'd9, 10);
        run_op(OP_ADD, 32'd11, 32'd22, 5'd1, -1);
        run_op(5'd19, 32'd1, 32'd2, 5'd1, -1);
        run_op(5'd24, 32'd3, 32'd4, 5'd1, -1);
        // Back-to-back: second op accepted the cycle after RESP
        run_op(OP_DIVU, 32'd12345, 32'd10, 5'd10, -1);
        run_op(OP_REMU, 32'd12345, 32'd10, 5'd11, -1);
        // Flush in the DONE cycle and in the RESP cycle
        run_op(OP_DIVU, 32'd77, 32'd5, 5'd12, 34);
        run_op(OP_DIVU, 32'd77, 32'd5, 5'd13, 35);

        // Random ops
        for (int n = 0; n < 24; n++) begin
            sel = $urandom_range(0, 6);
            case (sel)
                0, 1, 2, 3: op = 5'(20 + sel);
                4:          op = OP_ADD;
                5:          op = 5'd19;
                default:    op = 5'd24;
            endcase
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(1, 1000);
            if ($urandom_range(0, 7) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ref_lat(op, a, b) + 1) : -1;
            run_op(op, a, b, 5'($urandom), fl);
        end

        // Watchdog: ALU never pulses ready
        alu_en = 1'b0;
        for (int k = 0; k <= 65; k++) begin
            bus.req_valid = (k <= 64); bus.req_aluc = (k <= 64) ? OP_DIVU : OP_ADD;
            bus.req_a = 32'd50; bus.req_b = 32'd3; bus.req_rd = 5'd2; bus.flush = 1'b0;
            @(negedge clk);
            chk("wd_stall", {31'd0, bus.stall}, {31'd0, (k <= 64)});
            chk("wd_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
            if ((k == 64) || (k == 65)) begin
                chk("wd_timeout", {31'd0, bus.timeout_err}, {31'd0, (k == 65)});
            end
            @(posedge clk); #1;
        end
        exp_perf = exp_perf + 32'd65;
        @(negedge clk);
        chk("wd_perf", bus.perf_stall_cycles, exp_perf);
        chk("wd_sticky", {31'd0, bus.timeout_err}, 32'd1);
        @(posedge clk); #1;

        // Reset while waiting aborts immediately
        bus.req_valid = 1'b1; bus.req_aluc = OP_DIV; bus.req_a = 32'd9; bus.req_b = 32'd2;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_aluc = 5'd0; bus.req_a = 32'd0; bus.req_b = 32'd0;
        #1;
        chk("arst_stall", {31'd0, bus.stall}, 32'd0);
        chk("arst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("arst_wb_data", bus.wb_data, 32'd0);
        chk("arst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        chk("arst_timeout", {31'd0, bus.timeout_err}, 32'd0);
        chk("arst_perf", bus.perf_stall_cycles, 32'd0);
        chk("arst_aluc", {27'd0, bus.alu_aluc}, 32'd0);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        alu_en   = 1'b1;
        exp_perf = 32'd0;
        @(posedge clk); #1;
        run_op(OP_DIVU, 32'd100, 32'd7, 5'd3, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
